conv_in_sched: RTL and testbench

Sequencer for the convolution input path. It accepts a layer configuration and resets the input address generator. It then issues one 3×3 window read per cycle under a downstream credit limit, and tags each window with channel-last and image-last flags. Its window-valid stream follows BRAM read latency into the PE array, and it signals done once the final window has been delivered.

---
 rtl/conv_in_sched.sv | 210 +++++++++++++++++++++
 tb/tb_conv_in_sched.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/conv_in_sched.sv
// conv_in_sched -- convolution input-path sequencer.
//
// Latches a layer configuration, resets the input address generator, then
// issues one 3x3 window read per cycle while downstream credit is available.
// Each issued window is tagged with the generator's channel-last/image-last
// flags one cycle after issue, and its valid bit follows the BRAM read
// latency to the PE array. A done pulse follows the final window.
//
// Parameters:
//   BRAM_ADDR_BIT  generator address width (no address bus crosses this block)
//   RD_LAT         BRAM read latency, rd_en -> data valid (>= 1)
//   CREDITS        downstream window buffer depth (1..15)
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   start, abort                    image start pulse / flush request
//   cfg_width/channel/stride        layer configuration, sampled on start
//   ag_rst, ag_addr_inc             address generator reset / advance
//   ag_width/channel/stride         latched configuration to the generator
//   ag_channel_end, ag_img_end      generator flags for the window just advanced
//   rd_en                           BRAM window read
//   win_valid, win_chan_last,
//   win_img_last                    window stream into the PE array
//   win_consume                     downstream freed one buffer slot
//   busy, done, cfg_err             status
//
// Optional feature (macro CONV_IN_SCHED_WIN_CNT_EN):
//   adds output win_count[23:0], the number of windows delivered since LOAD.

module conv_in_sched #(
    parameter int BRAM_ADDR_BIT = 32,
    parameter int RD_LAT        = 2,
    parameter int CREDITS       = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [11:0] cfg_width,
    input  logic [11:0] cfg_channel,
    input  logic [2:0]  cfg_stride,
    output logic        ag_rst,
    output logic        ag_addr_inc,
    output logic [11:0] ag_width,
    output logic [11:0] ag_channel,
    output logic [2:0]  ag_stride,
    input  logic        ag_channel_end,
    input  logic        ag_img_end,
    output logic        rd_en,
    output logic        win_valid,
    output logic        win_chan_last,
    output logic        win_img_last,
    input  logic        win_consume,
    output logic        busy,
    output logic        done,
    output logic        cfg_err
`ifdef CONV_IN_SCHED_WIN_CNT_EN
    ,
    output logic [23:0] win_count
`endif
);

    if (RD_LAT < 1 || CREDITS < 1 || CREDITS > 15 || BRAM_ADDR_BIT < 1) begin : g_param_chk
        $error("conv_in_sched: parameter out of range");
    end

    localparam logic [3:0] LP_CREDITS = 4'(CREDITS);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [11:0]        r_width;
    logic [11:0]        r_channel;
    logic [2:0]         r_stride;
    logic [3:0]         r_credit;
    logic [RD_LAT-1:0]  r_vld_pipe;
    logic               r_ag_rst_hold;
    logic               r_cfg_err;
    logic               w_abort_take;
    logic               w_cfg_bad;
    logic               w_last_issued;
    logic               w_tag_cl;
    logic               w_tag_il;

    assign w_abort_take  = abort && (r_state == S_RUN || r_state == S_DRAIN);
    assign w_cfg_bad     = (r_width < 12'd3) || (r_stride == 3'd0) ||
                           (r_stride > 3'd4) || (r_channel == 12'd0);
    // Stage 0 of the valid pipe is rd_en delayed one cycle, so it marks the
    // cycles where the generator flags describe a freshly issued window.
    assign w_last_issued = r_vld_pipe[0] && ag_img_end;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_LOAD;
            S_LOAD:  w_state_nxt = w_cfg_bad ? S_IDLE : S_RUN;
            // With RD_LAT=1 the last window is emitted in RUN, so DONE can
            // be reached without passing through DRAIN.
            S_RUN: begin
                if (abort)                          w_state_nxt = S_IDLE;
                else if (win_valid && win_img_last) w_state_nxt = S_DONE;
                else if (w_last_issued)             w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (abort)                          w_state_nxt = S_IDLE;
                else if (win_valid && win_img_last) w_state_nxt = S_DONE;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        rd_en       = (r_state == S_RUN) && (r_credit != 4'd0) && !w_last_issued;
        ag_addr_inc = rd_en;
        ag_rst      = rst || r_ag_rst_hold || (r_state == S_LOAD);
        busy        = (r_state != S_IDLE);
        done        = (r_state == S_DONE);
    end

    assign cfg_err    = r_cfg_err;
    assign ag_width   = r_width;
    assign ag_channel = r_channel;
    assign ag_stride  = r_stride;

    // Generator reset is held one cycle past rst/abort.
    always_ff @(posedge clk) begin
        r_ag_rst_hold <= rst || w_abort_take;
        r_cfg_err     <= !rst && (r_state == S_LOAD) && w_cfg_bad;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_width   <= '0;
            r_channel <= '0;
            r_stride  <= '0;
        end else if (r_state == S_IDLE && start) begin
            r_width   <= cfg_width;
            r_channel <= cfg_channel;
            r_stride  <= cfg_stride;
        end
    end

    // Issue and consume in the same cycle cancel; a consume at full credit
    // is a spurious return and is dropped.
    always_ff @(posedge clk) begin
        if (rst || w_abort_take)
            r_credit <= LP_CREDITS;
        else if (rd_en && !win_consume)
            r_credit <= r_credit - 4'd1;
        else if (!rd_en && win_consume && r_credit != LP_CREDITS)
            r_credit <= r_credit + 4'd1;
    end

    always_ff @(posedge clk) begin
        if (rst || w_abort_take) begin
            r_vld_pipe <= '0;
        end else begin
            r_vld_pipe[0] <= rd_en;
            for (int i = 1; i < RD_LAT; i++) r_vld_pipe[i] <= r_vld_pipe[i-1];
        end
    end

    // Tags arrive one cycle after issue, i.e. alongside stage 0.
    if (RD_LAT == 1) begin : g_tag_bypass
        assign w_tag_cl = ag_channel_end;
        assign w_tag_il = ag_img_end;
    end else begin : g_tag_pipe
        logic [RD_LAT-1:1][1:0] r_tag;
        always_ff @(posedge clk) begin
            if (rst || w_abort_take) begin
                r_tag <= '0;
            end else begin
                r_tag[1] <= r_vld_pipe[0] ? {ag_channel_end, ag_img_end} : 2'b00;
                for (int i = 2; i < RD_LAT; i++) r_tag[i] <= r_tag[i-1];
            end
        end
        assign w_tag_cl = r_tag[RD_LAT-1][1];
        assign w_tag_il = r_tag[RD_LAT-1][0];
    end

    assign win_valid     = r_vld_pipe[RD_LAT-1];
    assign win_chan_last = win_valid && w_tag_cl;
    assign win_img_last  = win_valid && w_tag_il;

`ifdef CONV_IN_SCHED_WIN_CNT_EN
    logic [23:0] r_win_count;
    always_ff @(posedge clk) begin
        if (rst || w_abort_take || r_state == S_LOAD) r_win_count <= '0;
        else if (win_valid)                           r_win_count <= r_win_count + 24'd1;
    end
    assign win_count = r_win_count;
`endif

endmodule

// File: tb/tb_conv_in_sched.sv
// Self-checking bench for conv_in_sched. The bench plays the address
// generator and the downstream buffer, and predicts every output from the
// transaction-level rules: window counts from width/stride/channel, credit as
// a bounded counter, and a queue of expected window arrivals.
module tb_conv_in_sched;
    localparam int RD_LAT  = 2;
    localparam int CREDITS = 4;

    logic        clk = 1'b0;
    logic        rst, start, abort;
    logic [11:0] cfg_width, cfg_channel;
    logic [2:0]  cfg_stride;
    logic        ag_rst, ag_addr_inc;
    logic [11:0] ag_width, ag_channel;
    logic [2:0]  ag_stride;
    logic        ag_channel_end, ag_img_end;
    logic        rd_en, win_valid, win_chan_last, win_img_last;
    logic        win_consume;
    logic        busy, done, cfg_err;
`ifdef CONV_IN_SCHED_WIN_CNT_EN
    logic [23:0] win_count;
`endif

    always #5 clk = ~clk;

    conv_in_sched #(.BRAM_ADDR_BIT(32), .RD_LAT(RD_LAT), .CREDITS(CREDITS)) u_dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .cfg_width(cfg_width), .cfg_channel(cfg_channel), .cfg_stride(cfg_stride),
        .ag_rst(ag_rst), .ag_addr_inc(ag_addr_inc),
        .ag_width(ag_width), .ag_channel(ag_channel), .ag_stride(ag_stride),
        .ag_channel_end(ag_channel_end), .ag_img_end(ag_img_end),
        .rd_en(rd_en), .win_valid(win_valid), .win_chan_last(win_chan_last),
        .win_img_last(win_img_last), .win_consume(win_consume),
        .busy(busy), .done(done), .cfg_err(cfg_err)
`ifdef CONV_IN_SCHED_WIN_CNT_EN
        , .win_count(win_count)
`endif
    );

    typedef struct { int t; bit cl; bit il; } win_t;
    win_t expq[$];

    int n_chk = 0, n_pass = 0;
    int cyc = 0;
    // reference model of the sequencer
    bit m_active = 0, m_ok = 0;
    int m_s = -100, m_N = 0, m_per = 0, m_issued = 0, m_credit = CREDITS;
    int m_done_cyc = -1, m_err_cyc = -1, m_agrst_cyc = -1, m_cnt = 0;
    int m_W = 0, m_C = 0, m_S = 0;
    int n_val = 0, n_rd = 0, first_val = -1;
    // bench-side generator and consumer
    int gen_cnt = 0;
    bit prev_rd = 0;
    int cmode = 0;   // 0: no consume, 1: consume = win_valid, 2: random, 3: driven by caller

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    endtask

    task automatic cyc_step();
        bit   exp_rd, exp_val, idle_now;
        win_t f;
        if (prev_rd && m_per > 0) begin
            ag_channel_end = (gen_cnt % m_per) == 0;
            ag_img_end     = gen_cnt == m_N;
        end else begin
            // stale flags: the sequencer must not react to them
            ag_channel_end = 1'($urandom_range(0, 1));
            ag_img_end     = 1'($urandom_range(0, 1));
        end
        if (cmode == 0) win_consume = 1'b0;
        else if (cmode == 2) win_consume = ($urandom_range(0, 2) == 0);
        #1;
        if (cmode == 1) win_consume = win_valid;
        #1;
        exp_val = expq.size() > 0 && expq[0].t == cyc;
        exp_rd  = m_active && m_ok && cyc >= m_s + 2 && m_issued < m_N && m_credit > 0;
        chk("ag_rst", ag_rst, rst || cyc == m_agrst_cyc || (m_active && cyc == m_s + 1));
        if (!rst) begin
            chk("rd_en", rd_en, exp_rd);
            chk("ag_addr_inc", ag_addr_inc, exp_rd);
            chk("win_valid", win_valid, exp_val);
            if (exp_val) begin
                chk("win_chan_last", win_chan_last, expq[0].cl);
                chk("win_img_last", win_img_last, expq[0].il);
            end
            chk("done", done, cyc == m_done_cyc);
            chk("busy", busy, m_active);
            chk("cfg_err", cfg_err, cyc == m_err_cyc);
            chk("ag_width", ag_width, m_W);
            chk("ag_channel", ag_channel, m_C);
            chk("ag_stride", ag_stride, m_S);
`ifdef CONV_IN_SCHED_WIN_CNT_EN
            chk("win_count", win_count, m_cnt);
`endif
        end
        idle_now = !m_active;
        if (rst) begin
            m_active = 0; expq.delete(); m_credit = CREDITS; m_agrst_cyc = cyc + 1;
            m_done_cyc = -1; m_err_cyc = -1; m_W = 0; m_C = 0; m_S = 0; m_cnt = 0;
        end else if (abort && m_active && cyc >= m_s + 2 && cyc != m_done_cyc) begin
            m_active = 0; expq.delete(); m_credit = CREDITS; m_agrst_cyc = cyc + 1;
            m_done_cyc = -1; m_cnt = 0;
        end else begin
            if (exp_rd && !win_consume) m_credit--;
            else if (!exp_rd && win_consume && m_credit < CREDITS) m_credit++;
            if (exp_rd) begin
                m_issued++;
                expq.push_back('{cyc + RD_LAT, (m_issued % m_per) == 0, m_issued == m_N});
            end
            if (exp_val) begin
                f = expq.pop_front();
                n_val++; m_cnt++;
                if (first_val < 0) first_val = cyc;
                if (f.il) m_done_cyc = cyc + 1;
            end
            if (m_active && cyc == m_s + 1) begin
                m_cnt = 0;
                if (!m_ok) begin m_active = 0; m_err_cyc = cyc + 1; end
            end
            if (cyc == m_done_cyc) m_active = 0;
            if (idle_now && start) begin
                m_s = cyc; m_active = 1;
                m_W = int'(cfg_width); m_C = int'(cfg_channel); m_S = int'(cfg_stride);
                m_ok  = m_W >= 3 && m_S >= 1 && m_S <= 4 && m_C >= 1;
                m_per = m_ok ? ((m_W - 3) / m_S + 1) * ((m_W - 3) / m_S + 1) : 0;
                m_N   = m_per * m_C;
                m_issued = 0; m_done_cyc = -1; n_val = 0; n_rd = 0; first_val = -1;
            end
        end
        if (ag_rst) begin gen_cnt = 0; prev_rd = 0; end
        else if (ag_addr_inc) begin gen_cnt++; prev_rd = 1; end
        else prev_rd = 0;
        if (ag_addr_inc) n_rd++;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic finish_run(input int budget);
        int k;
        for (k = 0; k < budget && m_active; k++) cyc_step();
        chk("run_timeout", int'(k >= budget), 0);
        repeat (3) cyc_step();
    endtask

    task automatic run_img(input int w, input int s, input int c, input int cm,
                           input int abort_at, input int rst_at, input int busy_start_at);
        int  k;
        bit  ab_done, rst_done;
        ab_done = 0; rst_done = 0;
        cfg_width = 12'(w); cfg_stride = 3'(s); cfg_channel = 12'(c); cmode = cm;
        start = 1'b1;
        cyc_step();
        start = 1'b0;
        for (k = 0; k < 3000 && m_active; k++) begin
            if (k == busy_start_at) begin start = 1'b1; cfg_width = 12'd9; end
            if (abort_at >= 0 && n_val == abort_at && !ab_done) begin abort = 1'b1; ab_done = 1; end
            if (rst_at >= 0 && n_val == rst_at && !rst_done) begin
                rst = 1'b1; rst_done = 1; cyc_step();
            end
            cyc_step();
            start = 1'b0; abort = 1'b0; rst = 1'b0;
        end
        chk("run_timeout", int'(k >= 3000), 0);
        repeat (3) cyc_step();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; win_consume = 1'b0;
        cfg_width = '0; cfg_channel = '0; cfg_stride = '0;
        ag_channel_end = 1'b0; ag_img_end = 1'b0;
        repeat (3) cyc_step();
        rst = 1'b0;
        repeat (3) cyc_step();

        // 5x5, stride 1, 2 channels: 18 windows, chan_last on 9 and 18
        run_img(5, 1, 2, 1, -1, -1, -1);
        chk("n_windows_5x5", n_val, 18);

        // 7x7, stride 2, 1 channel: 9 windows, first valid 2+RD_LAT after start
        run_img(7, 2, 1, 1, -1, -1, -1);
        chk("n_windows_7x7", n_val, 9);
        chk("first_valid_lat", first_val - m_s, 2 + RD_LAT);

        // credit limit with no consumer
        cfg_width = 12'd7; cfg_stride = 3'd1; cfg_channel = 12'd1; cmode = 0;
        start = 1'b1; cyc_step(); start = 1'b0;
        repeat (12) cyc_step();
        chk("credit_stall", n_rd, CREDITS);
        cmode = 3; win_consume = 1'b1; cyc_step(); win_consume = 1'b0;
        repeat (4) cyc_step();
        chk("credit_one_more", n_rd, CREDITS + 1);
        // consume over two cycles: the second coincides with an issue
        win_consume = 1'b1; cyc_step(); cyc_step(); win_consume = 1'b0;
        repeat (4) cyc_step();
        chk("credit_same_cycle", n_rd, CREDITS + 3);
        cmode = 2;
        finish_run(3000);
        chk("n_windows_credit", n_val, 25);

        // rejected configurations
        run_img(7, 0, 1, 1, -1, -1, -1);
        chk("no_rd_stride0", n_rd, 0);
        run_img(2, 1, 1, 1, -1, -1, -1);
        chk("no_rd_width2", n_rd, 0);
        run_img(6, 5, 1, 1, -1, -1, -1);
        chk("no_rd_stride5", n_rd, 0);
        run_img(6, 1, 0, 1, -1, -1, -1);
        chk("no_rd_chan0", n_rd, 0);

        // abort after 5 windows, then a clean full run
        run_img(7, 2, 1, 1, 5, -1, -1);
        chk("abort_windows", n_val, 5);
        run_img(7, 2, 1, 1, -1, -1, -1);
        chk("n_windows_after_abort", n_val, 9);

        // start while busy is ignored, then rst mid-run, then a clean run
        run_img(5, 1, 1, 1, -1, 4, 2);
        run_img(5, 1, 1, 1, -1, -1, -1);
        chk("n_windows_after_rst", n_val, 9);

        // randomized configurations and consumer behaviour
        for (int r = 0; r < 6; r++) begin
            int w, s, c;
            w = $urandom_range(3, 10); s = $urandom_range(1, 4); c = $urandom_range(1, 3);
            run_img(w, s, c, $urandom_range(1, 2), -1, -1, -1);
            chk("n_windows_rand", n_val, (((w - 3) / s + 1) ** 2) * c);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
